// File: rtl/rv32i_irq_ctrl.sv
// External interrupt controller feeding rv32i_soc.i_external_interrupt.
// Define IRQ_SYNC_EN to add a 2-flop synchronizer on every source line.
module rv32i_irq_ctrl #(
    parameter int NUM_SRC = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_SRC-1:0] i_src,
    input  logic               i_wr_en,
    input  logic               i_rd_en,
    input  logic [1:0]         i_addr,
    input  logic [31:0]        i_wdata,
    output logic [31:0]        o_rdata,
    output logic               o_ack,
    output logic               o_external_interrupt
);
    localparam int PAD = 32 - NUM_SRC;

    logic [NUM_SRC-1:0] r_s;
    logic [NUM_SRC-1:0] r_s_prev;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_enable;
    logic [NUM_SRC-1:0] r_edge;

    logic [NUM_SRC-1:0] w_set;
    logic [NUM_SRC-1:0] w_clr;
    logic [NUM_SRC-1:0] w_active;
    logic [NUM_SRC-1:0] w_claim_hot;
    logic [NUM_SRC-1:0] w_pending_next;
    logic [4:0]         w_claim_id;
    logic [31:0]        w_rd_mux;
    logic               w_w1c;
    logic               w_claim;
    logic               w_unused_wdata;

`ifdef IRQ_SYNC_EN
    logic [NUM_SRC-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
            r_s    <= '0;
        end else begin
            r_sync <= i_src;
            r_s    <= r_sync;
        end
    end
`else
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s <= '0;
        end else begin
            r_s <= i_src;
        end
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s_prev <= '0;
        end else begin
            r_s_prev <= r_s;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_set
            assign w_set[gi] = r_edge[gi] ? (r_s[gi] & ~r_s_prev[gi]) : r_s[gi];
        end
    endgenerate

    // Lowest set bit of the active vector is the claim winner.
    assign w_active    = r_pending & r_enable;
    assign w_claim_hot = w_active & (~w_active + NUM_SRC'(1));

    always_comb begin
        w_claim_id = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (w_active[k]) begin
                w_claim_id = 5'(k + 1);
            end
        end
    end

    assign w_w1c   = i_wr_en && (i_addr == 2'd0);
    assign w_claim = i_rd_en && (i_addr == 2'd2) && (w_claim_id != 5'd0);
    assign w_clr   = (w_w1c ? i_wdata[NUM_SRC-1:0] : '0) | (w_claim ? w_claim_hot : '0);
    // Set is OR-ed in after the clear so a colliding set always wins.
    assign w_pending_next = (r_pending & ~w_clr) | w_set;

    assign w_unused_wdata = ^i_wdata[31:NUM_SRC];

    always_comb begin
        w_rd_mux = '0;
        case (i_addr)
            2'd0:    w_rd_mux = {{PAD{1'b0}}, r_pending};
            2'd1:    w_rd_mux = {{PAD{1'b0}}, r_enable};
            2'd2:    w_rd_mux = {27'd0, w_claim_id};
            default: w_rd_mux = {{PAD{1'b0}}, r_edge};
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pending            <= '0;
            r_enable             <= '0;
            r_edge               <= '0;
            o_rdata              <= '0;
            o_ack                <= 1'b0;
            o_external_interrupt <= 1'b0;
        end else begin
            r_pending <= w_pending_next;
            if (i_wr_en && (i_addr == 2'd1)) begin
                r_enable <= i_wdata[NUM_SRC-1:0];
            end
            if (i_wr_en && (i_addr == 2'd3)) begin
                r_edge <= i_wdata[NUM_SRC-1:0];
            end
            if (i_rd_en) begin
                o_rdata <= w_rd_mux;
            end
            o_ack                <= i_wr_en | i_rd_en;
            o_external_interrupt <= |w_active;
        end
    end
endmodule

// File: tb/tb_rv32i_irq_ctrl.sv
// Self-checking bench for rv32i_irq_ctrl: directed table, corner sequences,
// and randomized traffic against a cycle-level behavioural model.
module tb_rv32i_irq_ctrl;
    localparam int N = 8;
`ifdef IRQ_SYNC_EN
    localparam int D = 2;
`else
    localparam int D = 1;
`endif
    localparam int LAT = D + 2;

    logic        clk;
    logic        i_rst;
    logic [N-1:0] i_src;
    logic        i_wr_en;
    logic        i_rd_en;
    logic [1:0]  i_addr;
    logic [31:0] i_wdata;
    logic [31:0] o_rdata;
    logic        o_ack;
    logic        o_external_interrupt;

    rv32i_irq_ctrl #(.NUM_SRC(N)) dut (
        .i_clk                (clk),
        .i_rst                (i_rst),
        .i_src                (i_src),
        .i_wr_en              (i_wr_en),
        .i_rd_en              (i_rd_en),
        .i_addr               (i_addr),
        .i_wdata              (i_wdata),
        .o_rdata              (o_rdata),
        .o_ack                (o_ack),
        .o_external_interrupt (o_external_interrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic        exp_ack;
        logic [31:0] exp_rdata;
    } vec_t;

    localparam int NV = 16;
    vec_t vec [NV];

    logic [7:0] hist [$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp, input bit quiet = 1'b0);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end else if (!quiet) begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic wr, input logic rd, input logic [1:0] a,
                       input logic [31:0] wd, output logic [31:0] rdat, output logic ack);
        i_wr_en = wr;
        i_rd_en = rd;
        i_addr  = a;
        i_wdata = wd;
        tick();
        rdat    = o_rdata;
        ack     = o_ack;
        i_wr_en = 1'b0;
        i_rd_en = 1'b0;
    endtask

    task automatic wr_reg(input string name, input logic [1:0] a, input logic [31:0] wd);
        logic [31:0] v;
        logic        ak;
        bus(1'b1, 1'b0, a, wd, v, ak);
        chk({name, "_ack"}, {31'd0, ak}, 32'd1, 1'b1);
    endtask

    task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] v;
        logic        ak;
        bus(1'b0, 1'b1, a, 32'd0, v, ak);
        chk({name, "_ack"}, {31'd0, ak}, 32'd1, 1'b1);
        chk(name, v, exp);
    endtask

    task automatic do_reset(input int n, input logic [7:0] src);
        i_rst   = 1'b1;
        i_src   = src;
        i_wr_en = 1'b0;
        i_rd_en = 1'b0;
        for (int c = 0; c < n; c++) begin
            tick();
            chk("rst_ack", {31'd0, o_ack}, 32'd0, 1'b1);
            chk("rst_rdata", o_rdata, 32'd0, 1'b1);
            chk("rst_irq", {31'd0, o_external_interrupt}, 32'd0, 1'b1);
        end
        i_rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic        ak;
        int          n;
        logic [7:0]  m_pend, m_en, m_edge, s_now, s_old, act, clr, setv, src;
        logic [31:0] m_rdata, wd;
        logic        exp_irq, wr, rd;
        logic [1:0]  a;
        int          id;

        vec[0]  = '{1'b1, 1'b0, 2'd1, 32'h0000_0055, 1'b1, 32'h0000_0000};
        vec[1]  = '{1'b0, 1'b0, 2'd0, 32'h0000_0000, 1'b0, 32'h0000_0000};
        vec[2]  = '{1'b0, 1'b1, 2'd1, 32'h0000_0000, 1'b1, 32'h0000_0055};
        vec[3]  = '{1'b1, 1'b1, 2'd1, 32'h0000_00AA, 1'b1, 32'h0000_0055};
        vec[4]  = '{1'b0, 1'b0, 2'd0, 32'h0000_0000, 1'b0, 32'h0000_0055};
        vec[5]  = '{1'b0, 1'b1, 2'd1, 32'h0000_0000, 1'b1, 32'h0000_00AA};
        vec[6]  = '{1'b1, 1'b0, 2'd3, 32'hFFFF_FFF0, 1'b1, 32'h0000_00AA};
        vec[7]  = '{1'b0, 1'b1, 2'd3, 32'h0000_0000, 1'b1, 32'h0000_00F0};
        vec[8]  = '{1'b1, 1'b0, 2'd1, 32'hFFFF_FFFF, 1'b1, 32'h0000_00F0};
        vec[9]  = '{1'b0, 1'b1, 2'd1, 32'h0000_0000, 1'b1, 32'h0000_00FF};
        vec[10] = '{1'b0, 1'b1, 2'd0, 32'h0000_0000, 1'b1, 32'h0000_0000};
        vec[11] = '{1'b0, 1'b1, 2'd2, 32'h0000_0000, 1'b1, 32'h0000_0000};
        vec[12] = '{1'b1, 1'b0, 2'd2, 32'h0000_0003, 1'b1, 32'h0000_0000};
        vec[13] = '{1'b0, 1'b1, 2'd3, 32'h0000_0000, 1'b1, 32'h0000_00F0};
        vec[14] = '{1'b1, 1'b0, 2'd0, 32'h0000_00FF, 1'b1, 32'h0000_00F0};
        vec[15] = '{1'b0, 1'b0, 2'd0, 32'h0000_0000, 1'b0, 32'h0000_00F0};

        i_rst = 1'b1; i_src = '0; i_wr_en = 1'b0; i_rd_en = 1'b0;
        i_addr = 2'd0; i_wdata = '0;

        // Reset held with all lines high; ENABLE=0 keeps the request low.
        do_reset(3, 8'hFF);
        chk("rst_out_ack", {31'd0, o_ack}, 32'd0);
        chk("rst_out_irq", {31'd0, o_external_interrupt}, 32'd0);
        rd_chk("rst_pend", 2'd0, 32'h0);
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("rst_irq_low", {31'd0, o_external_interrupt}, 32'd0, 1'b1);
        end
        rd_chk("disabled_latches", 2'd0, 32'hFF);

        // Reset coinciding with a strobe yields no ack.
        i_rd_en = 1'b1; i_addr = 2'd0; i_rst = 1'b1;
        tick();
        chk("rst_strobe_ack", {31'd0, o_ack}, 32'd0);
        i_rd_en = 1'b0;

        // Level path latency, claim and re-pend.
        do_reset(2, 8'h00);
        wr_reg("lvl_en", 2'd1, 32'h04);
        wr_reg("lvl_edge", 2'd3, 32'h00);
        i_src = 8'h04;
        n = 0;
        while (!o_external_interrupt && n < 12) begin
            tick();
            n++;
        end
        chk("lvl_latency", n, LAT);
        rd_chk("lvl_claim", 2'd2, 32'd3);
        rd_chk("lvl_repend", 2'd0, 32'h04);
        i_src = 8'h00;

        // Edge path: pulse, claim, request falls two cycles after the strobe.
        do_reset(2, 8'h00);
        wr_reg("edge_edge", 2'd3, 32'h01);
        wr_reg("edge_en", 2'd1, 32'h01);
        i_src = 8'h01;
        repeat (D) tick();
        i_src = 8'h00;
        repeat (LAT + 1) tick();
        chk("edge_irq_up", {31'd0, o_external_interrupt}, 32'd1);
        rd_chk("edge_pend", 2'd0, 32'h01);
        bus(1'b0, 1'b1, 2'd2, 32'd0, v, ak);
        chk("edge_claim_ack", {31'd0, ak}, 32'd1, 1'b1);
        chk("edge_claim", v, 32'd1);
        chk("edge_irq_hold", {31'd0, o_external_interrupt}, 32'd1);
        tick();
        chk("edge_irq_fall", {31'd0, o_external_interrupt}, 32'd0);
        rd_chk("edge_pend_clr", 2'd0, 32'h00);

        // Priority and masking with back-to-back claims.
        do_reset(2, 8'h00);
        wr_reg("prio_en", 2'd1, 32'h48);
        i_src = 8'h4A;
        tick();
        i_src = 8'h00;
        repeat (LAT + 1) tick();
        rd_chk("prio_claim1", 2'd2, 32'd4);
        rd_chk("prio_claim2", 2'd2, 32'd7);
        rd_chk("prio_claim3", 2'd2, 32'd0);
        chk("prio_irq", {31'd0, o_external_interrupt}, 32'd0);
        rd_chk("prio_pend", 2'd0, 32'h02);

        // W1C landing in the same cycle as an edge set: set wins.
        do_reset(2, 8'h00);
        wr_reg("coll_edge", 2'd3, 32'h20);
        i_src = 8'h20;
        repeat (D) tick();
        wr_reg("coll_w1c", 2'd0, 32'h20);
        rd_chk("coll_pend", 2'd0, 32'h20);
        wr_reg("coll_w1c2", 2'd0, 32'h20);
        rd_chk("coll_clr", 2'd0, 32'h00);
        i_src = 8'h00;

        // Register table, applied back to back.
        do_reset(2, 8'h00);
        for (int i = 0; i < NV; i++) begin
            bus(vec[i].wr, vec[i].rd, vec[i].addr, vec[i].wdata, v, ak);
            chk($sformatf("vec%0d_ack", i), {31'd0, ak}, {31'd0, vec[i].exp_ack});
            chk($sformatf("vec%0d_rdata", i), v, vec[i].exp_rdata);
        end

        // Randomized traffic against the behavioural model.
        do_reset(2, 8'h00);
        hist = {};
        repeat (D + 2) hist.push_back(8'h00);
        m_pend = '0; m_en = '0; m_edge = '0; m_rdata = '0;
        for (int c = 0; c < 400; c++) begin
            src = 8'($urandom & $urandom & $urandom);
            wr  = ($urandom_range(0, 3) == 0);
            rd  = ($urandom_range(0, 2) == 0);
            a   = 2'($urandom_range(0, 3));
            wd  = $urandom;
            i_src = src; i_wr_en = wr; i_rd_en = rd; i_addr = a; i_wdata = wd;

            hist.push_front(src);
            void'(hist.pop_back());
            s_now = hist[D];
            s_old = hist[D + 1];

            act = m_pend & m_en;
            id  = 0;
            for (int k = N - 1; k >= 0; k--) begin
                if (act[k]) id = k + 1;
            end
            if (rd) begin
                case (a)
                    2'd0:    m_rdata = {24'd0, m_pend};
                    2'd1:    m_rdata = {24'd0, m_en};
                    2'd2:    m_rdata = 32'(id);
                    default: m_rdata = {24'd0, m_edge};
                endcase
            end
            exp_irq = (act != 8'd0);
            clr = '0;
            if (wr && a == 2'd0) clr = wd[7:0];
            if (rd && a == 2'd2 && id != 0) clr[id - 1] = 1'b1;
            for (int k = 0; k < N; k++) begin
                setv[k] = m_edge[k] ? (s_now[k] && !s_old[k]) : s_now[k];
            end

            tick();
            chk($sformatf("rnd%0d_ack", c), {31'd0, o_ack}, {31'd0, wr | rd}, 1'b1);
            chk($sformatf("rnd%0d_rdata", c), o_rdata, m_rdata, 1'b1);
            chk($sformatf("rnd%0d_irq", c), {31'd0, o_external_interrupt}, {31'd0, exp_irq}, 1'b1);
            if (wr || rd) begin
                $display("rnd %0d wr=%0b rd=%0b addr=%0d wdata=%08h rdata=%08h irq=%0b",
                         c, wr, rd, a, wd, o_rdata, o_external_interrupt);
            end

            m_pend = (m_pend & ~clr) | setv;
            if (wr && a == 2'd1) m_en = wd[7:0];
            if (wr && a == 2'd3) m_edge = wd[7:0];
        end
        i_wr_en = 1'b0; i_rd_en = 1'b0; i_src = '0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rv32i_irq_ctrl.md
# rv32i_irq_ctrl

External interrupt controller that sits directly upstream of `rv32i_soc` and drives its `i_external_interrupt` input. It samples up to 31 external sources, latches each as pending (level or rising-edge), masks them with an enable register, and asserts a single registered interrupt request. A small register port lets the trap handler read pending state, program enables and edge modes, and claim the highest-priority source.

## Interface
- `NUM_SRC`, default 8: number of sources, legal range 1..31.
- `i_clk` input, 1 bit: clock.
- `i_rst` input, 1 bit: reset, synchronous, active-high.
- `i_src` input, NUM_SRC bits: raw external interrupt lines.
- `i_wr_en` input, 1 bit: register write strobe.
- `i_rd_en` input, 1 bit: register read strobe.
- `i_addr` input, 2 bits: register select.
- `i_wdata` input, 32 bits: write data.
- `o_rdata` output, 32 bits: read data, valid when `o_ack`=1.
- `o_ack` output, 1 bit: one-cycle acknowledge for a read or write.
- `o_external_interrupt` output, 1 bit: to `rv32i_soc.i_external_interrupt`.

## Operation
- Registers, with bits above NUM_SRC read as 0 and writes to them ignored:
  - addr 0, PENDING: read returns the pending vector. Writing 1 to a bit clears it (W1C).
  - addr 1, ENABLE: read/write mask.
  - addr 2, CLAIM: read returns the ID of the lowest-index pending and enabled source, as index+1. Returns 0 if no such source. A nonzero claim clears that pending bit. Writes are ignored.
  - addr 3, EDGE: read/write. 1 selects rising-edge mode, 0 selects level mode.
- Sampling: `s` is the sampled source vector and `s_prev` is `s` delayed by 1 cycle.
- Pending set condition:
  - level mode: `s[k]`=1.
  - edge mode: `s[k]`=1 and `s_prev[k]`=0.
- Pending is not gated by ENABLE. A disabled source still latches pending.
- When a set and a clear (W1C or claim) hit the same bit in the same cycle, set wins.
- In level mode, a claimed source with its line still high re-pends on the next cycle. The handler must silence the device first.
- `o_external_interrupt` is registered as `|(pending & enable)`.
- If `i_wr_en` and `i_rd_en` are both high, both are performed. The read returns the pre-write value and a single `o_ack` pulse is issued.
- Reset clears PENDING, ENABLE, EDGE, the sync/sample flops and `s_prev`.
- Output reset values: `o_rdata`=0, `o_ack`=0, `o_external_interrupt`=0.
- A reset mid-transaction drops any pending ack.

## Timing
- Register access:
  - `o_ack` rises 1 cycle after the strobe and lasts exactly 1 cycle.
  - `o_rdata` is held between acks.
  - A write takes effect at the same edge that raises `o_ack`.
  - Strobes are single-cycle. Back-to-back strobes every cycle are supported.
- Source to pending: 1 cycle after `s` shows the set condition.
- Pending to `o_external_interrupt`: 1 further cycle.
- CLAIM:
  - The ID is computed from pending state at the strobe cycle.
  - `o_external_interrupt` deasserts 2 cycles after the claim strobe if no other enabled source is pending.
- ENABLE write: affects `o_external_interrupt` 1 cycle after the `o_ack` edge.

## Configuration
- `IRQ_SYNC_EN`:
  - Defined: each `i_src` bit passes through a 2-flop synchronizer before `s`.
  - Total latency from the `i_src` rise to `o_external_interrupt` is 4 cycles.
- Not defined:
  - `s` is a single register of `i_src`, for synchronous on-chip sources.
  - Latency is 3 cycles.

## Test plan
- Reset: hold `i_rst` for 3 cycles with `i_src`=8'hFF.
  - Expect all outputs at 0 and PENDING reads 0 immediately after release.
  - ENABLE=0, so `o_external_interrupt` stays 0 throughout.
- Level path: write ENABLE=8'h04, EDGE=0, drive `i_src[2]`=1.
  - `o_external_interrupt` rises exactly 4 cycles later with `IRQ_SYNC_EN`, 3 without.
  - CLAIM reads 3.
  - With `i_src[2]` still high, PENDING re-reads 8'h04.
- Edge path: EDGE=8'h01, ENABLE=8'h01, pulse `i_src[0]` for 1 cycle (`IRQ_SYNC_EN` undefined), 2 cycles with `IRQ_SYNC_EN`.
  - PENDING=8'h01.
  - CLAIM reads 1.
  - PENDING then reads 0 and `o_external_interrupt` falls 2 cycles after the claim strobe.
- Priority and masking: pend sources 1, 3 and 6 with ENABLE=8'h48.
  - CLAIM returns 4, then 7, then 0.
  - PENDING bit 1 is still set and `o_external_interrupt`=0 after the third claim.
- Set/clear collision: in edge mode, W1C PENDING=8'h20 in the same cycle that source 5's edge sets it.
  - Bit 5 remains 1.
- Simultaneous read and write on addr 1: `i_wdata`=8'hAA with old ENABLE=8'h55.
  - `o_rdata`=8'h55 with a single `o_ack`.
  - The next read returns 8'hAA.
